// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: register addresses and sizing for the interrupt controller
package interrupt_controller_pkg;
  localparam int INTC_NSRC = 8;
  localparam logic [63:0] TIMER_CNT_ADDR  = 64'h0000_0000_0000_1000;
  localparam logic [63:0] TIMER_CRL_ADDR  = 64'h0000_0000_0000_1008;
  localparam logic [63:0] INTC_MASK_ADDR  = 64'h0000_0000_0000_1010;
  localparam logic [63:0] INTC_PEND_ADDR  = 64'h0000_0000_0000_1018;
  localparam logic [63:0] INTC_CLAIM_ADDR = 64'h0000_0000_0000_1020;
  localparam logic [63:0] INTC_DONE_ADDR  = 64'h0000_0000_0000_1028;
endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// priority_encoder: valid flag and index of the lowest set request bit
module priority_encoder #(
  parameter int N = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);
  // scan from the top so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? IW'(i) : idx;
  end
  assign valid = |req;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: masked fixed-priority IRQ with claim/complete over the data bus; INTC_EDGE_EN selects edge-latched pending
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int width = 64,
  parameter int NSRC  = INTC_NSRC
) (
  input  logic             clock,
  input  logic             reset,
  output logic             irq,
  output logic [width-1:0] rdata,
  output logic             IntcAddress,
  input  logic [NSRC-1:0]  src,
  input  logic             enable,
  input  logic [width-1:0] data,
  input  logic [width-1:0] address,
  input  logic             MemRead,
  input  logic             MemWrite
);
  localparam int ID_W = $clog2(NSRC + 1);
  localparam int IW   = (NSRC > 1) ? $clog2(NSRC) : 1;
  logic [NSRC-1:0] mask_Q, pending_Q, inserv_Q, eligible, claim_oh, done_oh;
  logic [IW-1:0]   idx;
  logic            valid, hit_mask, hit_pend, hit_claim, hit_done;
  logic [ID_W-1:0] k;
  logic [width-1:0] rd_data;
`ifdef INTC_EDGE_EN
  logic [NSRC-1:0] src_prev;
`endif
  assign hit_mask    = enable && address == width'(INTC_MASK_ADDR);
  assign hit_pend    = enable && address == width'(INTC_PEND_ADDR);
  assign hit_claim   = enable && address == width'(INTC_CLAIM_ADDR);
  assign hit_done    = enable && address == width'(INTC_DONE_ADDR);
  assign IntcAddress = hit_mask | hit_pend | hit_claim | hit_done;
  assign eligible    = pending_Q & mask_Q & ~inserv_Q;
  assign k           = data[ID_W-1:0];
  priority_encoder #(.N(NSRC)) u_pe (.req(eligible), .valid(valid), .idx(idx));
  // one-hot claim/complete strobes and the read mux
  always_comb begin
    claim_oh = (hit_claim && MemRead && valid) ? NSRC'(1) << idx : '0;
    done_oh  = (hit_done && MemWrite && k != '0 && int'(k) <= NSRC) ? NSRC'(1) << (k - ID_W'(1)) : '0;
    rd_data  = hit_mask ? width'(mask_Q) :
               hit_pend ? width'(pending_Q) :
               (hit_claim && valid) ? width'(idx) + width'(1) : '0;
  end
  assign rdata = (IntcAddress && MemRead) ? rd_data : 'z;
  // controller state; the claimed source is dropped from irq at the claim edge itself
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      mask_Q    <= '0;
      pending_Q <= '0;
      inserv_Q  <= '0;
      irq       <= 1'b0;
`ifdef INTC_EDGE_EN
      src_prev  <= '0;
`endif
    end else begin
      if (hit_mask && MemWrite) mask_Q <= data[NSRC-1:0];
`ifdef INTC_EDGE_EN
      pending_Q <= (pending_Q & ~claim_oh) | (src & ~src_prev);
      src_prev  <= src;
`else
      pending_Q <= src;
`endif
      inserv_Q  <= (inserv_Q | claim_oh) & ~done_oh;
      irq       <= |(eligible & ~claim_oh);
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed plus random stimulus against a per-source reference model
module tb_interrupt_controller;
  import interrupt_controller_pkg::*;
  logic        clock = 0, reset = 0, irq, IntcAddress;
  logic [63:0] rdata, data = 0, address = 0;
  logic [7:0]  src = 0;
  logic        enable = 0, MemRead = 0, MemWrite = 0;
  int n_total = 0, n_pass = 0;
  int m_mask[8], m_pend[8], m_inserv[8], m_prev[8], m_irq;
  logic [63:0] rd;
  logic [63:0] addrs[5];

  interrupt_controller #(.width(64), .NSRC(8)) dut (
    .clock(clock), .reset(reset), .irq(irq), .rdata(rdata), .IntcAddress(IntcAddress),
    .src(src), .enable(enable), .data(data), .address(address),
    .MemRead(MemRead), .MemWrite(MemWrite)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pack(input int v[8]);
    logic [63:0] r = 0;
    for (int i = 0; i < 8; i++) if (v[i] != 0) r[i] = 1'b1;
    return r;
  endfunction

  // one bus cycle: drive after the falling edge, check bus outputs, advance model at the rising edge, check irq
  task automatic cyc(input logic en, input logic rdn, input logic wr, input logic [63:0] a,
                     input logic [63:0] d, input logic [7:0] s, output logic [63:0] obs);
    int first, claimed, any, kk;
    logic hit;
    logic [63:0] exp_rd;
    enable = en; MemRead = rdn; MemWrite = wr; address = a; data = d; src = s;
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin m_mask[i] = 0; m_pend[i] = 0; m_inserv[i] = 0; m_prev[i] = 0; end
      m_irq = 0;
    end
    #1;
    hit = en && (a == INTC_MASK_ADDR || a == INTC_PEND_ADDR || a == INTC_CLAIM_ADDR || a == INTC_DONE_ADDR);
    first = -1;
    for (int i = 0; i < 8; i++)
      if (first < 0 && m_pend[i] != 0 && m_mask[i] != 0 && m_inserv[i] == 0) first = i;
    if (!(hit && rdn)) exp_rd = 'z;
    else if (a == INTC_MASK_ADDR) exp_rd = pack(m_mask);
    else if (a == INTC_PEND_ADDR) exp_rd = pack(m_pend);
    else if (a == INTC_CLAIM_ADDR) exp_rd = 64'(first + 1);
    else exp_rd = 0;
    chk("hit", {63'b0, IntcAddress}, {63'b0, hit});
    chk("rdata", rdata, exp_rd);
    obs = rdata;
    @(posedge clock);
    if (reset) begin
      claimed = (hit && rdn && a == INTC_CLAIM_ADDR) ? first : -1;
      any = 0;
      for (int i = 0; i < 8; i++)
        if (m_pend[i] != 0 && m_mask[i] != 0 && m_inserv[i] == 0 && i != claimed) any = 1;
      m_irq = any;
      if (hit && wr && a == INTC_MASK_ADDR) for (int i = 0; i < 8; i++) m_mask[i] = int'(d[i]);
      if (claimed >= 0) m_inserv[claimed] = 1;
      if (hit && wr && a == INTC_DONE_ADDR) begin
        kk = int'(d[3:0]);
        if (kk >= 1 && kk <= 8) m_inserv[kk-1] = 0;
      end
      for (int i = 0; i < 8; i++) begin
`ifdef INTC_EDGE_EN
        if (s[i] && m_prev[i] == 0) m_pend[i] = 1;
        else if (i == claimed) m_pend[i] = 0;
`else
        m_pend[i] = int'(s[i]);
`endif
        m_prev[i] = int'(s[i]);
      end
    end
    @(negedge clock);
    chk("irq", {63'b0, irq}, {63'b0, m_irq[0]});
  endtask

  initial begin
    logic [63:0] a, d;
    logic [7:0] s;
    addrs[0] = INTC_MASK_ADDR; addrs[1] = INTC_PEND_ADDR; addrs[2] = INTC_CLAIM_ADDR;
    addrs[3] = INTC_DONE_ADDR; addrs[4] = TIMER_CNT_ADDR;
    // reset held with all sources active
    reset = 0;
    @(negedge clock);
    cyc(1, 1, 0, INTC_PEND_ADDR, 0, 8'hFF, rd);
    chk("rst_pend", rd, 0);
    cyc(1, 1, 0, INTC_MASK_ADDR, 0, 8'hFF, rd);
    chk("rst_mask", rd, 0);
    reset = 1;
    repeat (3) cyc(0, 0, 0, 0, 0, 8'hFF, rd);
    // timer source: latency, claim, complete
    cyc(1, 0, 1, INTC_MASK_ADDR, 64'h01, 8'h00, rd);
    cyc(0, 0, 0, 0, 0, 8'h01, rd);
    cyc(0, 0, 0, 0, 0, 8'h01, rd);
    chk("irq_t2", {63'b0, irq}, 64'd1);
    cyc(1, 1, 0, INTC_CLAIM_ADDR, 0, 8'h01, rd);
    chk("claim_timer", rd, 64'd1);
    chk("irq_after_claim", {63'b0, irq}, 64'd0);
    cyc(1, 0, 1, INTC_DONE_ADDR, 64'd1, 8'h01, rd);
    cyc(0, 0, 0, 0, 0, 8'h01, rd);
    // priority ordering
    cyc(1, 0, 1, INTC_MASK_ADDR, 64'hFF, 8'b0010_0100, rd);
    cyc(0, 0, 0, 0, 0, 8'b0010_0100, rd);
    cyc(1, 1, 0, INTC_CLAIM_ADDR, 0, 8'b0010_0100, rd);
    chk("claim_first", rd, 64'd3);
    cyc(1, 1, 0, INTC_CLAIM_ADDR, 0, 8'b0010_0100, rd);
    chk("claim_second", rd, 64'd6);
    cyc(1, 1, 0, INTC_CLAIM_ADDR, 0, 8'b0010_0100, rd);
    chk("claim_none", rd, 64'd0);
    cyc(1, 0, 1, INTC_DONE_ADDR, 64'd3, 8'b0010_0100, rd);
    cyc(1, 1, 0, INTC_CLAIM_ADDR, 0, 8'b0010_0100, rd);
`ifndef INTC_EDGE_EN
    chk("claim_again", rd, 64'd3);
`endif
    // completes with no effect, mask read-while-write
    cyc(1, 0, 1, INTC_DONE_ADDR, 64'd0, 8'b0010_0100, rd);
    cyc(1, 0, 1, INTC_DONE_ADDR, 64'd9, 8'b0010_0100, rd);
    cyc(1, 0, 1, INTC_DONE_ADDR, 64'd5, 8'b0010_0100, rd);
    cyc(1, 1, 0, INTC_PEND_ADDR, 0, 8'b0010_0100, rd);
    cyc(1, 1, 1, INTC_MASK_ADDR, 64'h0F, 8'b0010_0100, rd);
    chk("mask_rw_old", rd, 64'hFF);
    cyc(1, 1, 0, INTC_DONE_ADDR, 0, 8'b0010_0100, rd);
    // reset mid-service
    cyc(1, 0, 1, INTC_MASK_ADDR, 64'h01, 8'h01, rd);
    cyc(0, 0, 0, 0, 0, 8'h01, rd);
    cyc(1, 1, 0, INTC_CLAIM_ADDR, 0, 8'h01, rd);
    reset = 0;
    cyc(0, 0, 0, 0, 0, 8'h01, rd);
    reset = 1;
    cyc(1, 0, 1, INTC_MASK_ADDR, 64'h01, 8'h01, rd);
    cyc(0, 0, 0, 0, 0, 8'h01, rd);
    chk("irq_after_reset", {63'b0, irq}, 64'd1);
`ifdef INTC_EDGE_EN
    reset = 0;
    cyc(0, 0, 0, 0, 0, 8'h00, rd);
    reset = 1;
    cyc(1, 0, 1, INTC_MASK_ADDR, 64'h04, 8'h00, rd);
    cyc(0, 0, 0, 0, 0, 8'h04, rd);
    repeat (3) cyc(1, 1, 0, INTC_PEND_ADDR, 0, 8'h00, rd);
    chk("edge_pend", rd, 64'h04);
    cyc(1, 1, 0, INTC_CLAIM_ADDR, 0, 8'h04, rd);
    chk("edge_claim", rd, 64'd3);
    repeat (3) cyc(1, 1, 0, INTC_PEND_ADDR, 0, 8'h04, rd);
    chk("edge_no_repend", rd, 64'h00);
`endif
    // random traffic against the model
    s = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) s = 8'($urandom);
      a = addrs[$urandom_range(0, 4)];
      d = {$urandom, $urandom};
      if (a == INTC_DONE_ADDR && $urandom_range(0, 3) != 0) d = 64'($urandom_range(0, 10));
      cyc($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), a, d, s, rd);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
